// File: rtl/blk_buf_1p_ctrl.sv
// Fill/drain access controller for a single-port 128x64 block buffer RAM.
// Optional early block termination via wr_last_i when BLK_BUF_PARTIAL_EN is defined.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module blk_buf_1p_ctrl #(
    parameter int AW    = 7,
    parameter int DEPTH = 128,
    parameter int DW    = `PIXEL_WIDTH*8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_val_i,
    input  logic [DW-1:0] wr_dat_i,
`ifdef BLK_BUF_PARTIAL_EN
    input  logic          wr_last_i,
`endif
    output logic          wr_rdy_o,
    output logic          rd_val_o,
    output logic [DW-1:0] rd_dat_o,
    output logic          rd_last_o,
    input  logic          rd_rdy_i,
    output logic          ram_ce_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_dat_o,
    input  logic [DW-1:0] ram_dat_i,
    output logic          busy_o
);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t        state;
    logic [AW-1:0] waddr;
    logic [AW-1:0] last_addr;
    logic [AW:0]   rcnt;
    logic          inflight;
    logic          inflight_last;
    logic [DW-1:0] fifo_dat [2];
    logic [1:0]    fifo_last;
    logic          rptr;
    logic          wptr;
    logic [1:0]    fifo_cnt;

    logic accept;
    logic fill_end;
    logic pop;
    logic issue;

    always_comb begin
        accept   = (state == FILL) && wr_val_i && wr_rdy_o;
`ifdef BLK_BUF_PARTIAL_EN
        fill_end = accept && ((waddr == AW'(DEPTH-1)) || wr_last_i);
`else
        fill_end = accept && (waddr == AW'(DEPTH-1));
`endif
        pop      = rd_val_o && rd_rdy_i;
        // Credit rule: entries held plus the read in flight, less this cycle's pop, must leave room.
        issue    = (state == DRAIN) && (rcnt <= {1'b0, last_addr}) &&
                   (({1'b0, fifo_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
    end

    assign ram_ce_o   = accept || issue;
    assign ram_we_o   = accept;
    assign ram_addr_o = (state == DRAIN) ? rcnt[AW-1:0] : waddr;
    assign ram_dat_o  = wr_dat_i;
    assign rd_val_o   = (fifo_cnt != 2'd0);
    assign rd_dat_o   = fifo_dat[rptr];
    assign rd_last_o  = rd_val_o && fifo_last[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_rdy_o      <= 1'b0;
            busy_o        <= 1'b0;
            waddr         <= '0;
            last_addr     <= '1;
            rcnt          <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            fifo_dat[0]   <= '0;
            fifo_dat[1]   <= '0;
            fifo_last     <= '0;
            rptr          <= 1'b0;
            wptr          <= 1'b0;
            fifo_cnt      <= '0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (rcnt[AW-1:0] == last_addr);
            if (inflight) begin
                fifo_dat[wptr]  <= ram_dat_i;
                fifo_last[wptr] <= inflight_last;
                wptr            <= ~wptr;
            end
            if (pop)
                rptr <= ~rptr;
            fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
            if (issue)
                rcnt <= rcnt + 1'b1;

            case (state)
                IDLE: begin
                    state    <= FILL;
                    wr_rdy_o <= 1'b1;
                end
                FILL: begin
                    if (accept)
                        waddr <= waddr + 1'b1;
                    if (fill_end) begin
                        state     <= DRAIN;
                        wr_rdy_o  <= 1'b0;
                        busy_o    <= 1'b1;
                        waddr     <= '0;
                        last_addr <= waddr;
                    end
                end
                DRAIN: begin
                    if (pop && rd_last_o) begin
                        state    <= FILL;
                        wr_rdy_o <= 1'b1;
                        busy_o   <= 1'b0;
                        rcnt     <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blk_buf_1p_ctrl.sv
// Scoreboard bench for blk_buf_1p_ctrl with a behavioural single-port RAM.
// Partial-block case is exercised when BLK_BUF_PARTIAL_EN is defined.
module tb_blk_buf_1p_ctrl;

    localparam int AW    = 7;
    localparam int DEPTH = 128;
    localparam int DW    = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_val = 1'b0;
    logic [DW-1:0] wr_dat = '0;
    logic          wr_last = 1'b0;
    logic          wr_rdy;
    logic          rd_val;
    logic [DW-1:0] rd_dat;
    logic          rd_last;
    logic          rd_rdy = 1'b1;
    logic          ram_ce;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdat;
    logic [DW-1:0] ram_rdat = '0;
    logic          busy;

    blk_buf_1p_ctrl #(.AW(AW), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_val_i(wr_val), .wr_dat_i(wr_dat),
`ifdef BLK_BUF_PARTIAL_EN
        .wr_last_i(wr_last),
`endif
        .wr_rdy_o(wr_rdy),
        .rd_val_o(rd_val), .rd_dat_o(rd_dat), .rd_last_o(rd_last), .rd_rdy_i(rd_rdy),
        .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_dat_o(ram_wdat), .ram_dat_i(ram_rdat), .busy_o(busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_ce && ram_we) mem[ram_addr] <= ram_wdat;
        if (ram_ce && !ram_we) ram_rdat <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { logic [DW-1:0] d; logic l; } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_fail = 0;
    int rdy_mode = 0;
    int ph = 0;
    int outstanding = 0;
    int pop_idx = 0;
    int first_pop_cyc = 0;
    int last_pop_cyc = 0;
    int last_wr_cyc = 0;
    bit lat_armed = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk); #1;
        ph = (ph + 1) % 4;
        rd_rdy = (rdy_mode == 0) ? 1'b1 : ((ph == 0) || (ph == 3));
    end

    // Monitor: pops against the scoreboard plus interface-level rules.
    always @(negedge clk) begin
        if (!rst_n) begin
            outstanding = 0;
        end else begin
            automatic int p = (rd_val && rd_rdy) ? 1 : 0;
            if (lat_armed && rd_val) begin
                check("first_read_latency", 64'(cyc - last_wr_cyc), 64'd3);
                lat_armed = 0;
            end
            if (p == 1) begin
                if (sb.size() == 0) begin
                    check("unexpected_pop", 64'd1, 64'd0);
                end else begin
                    automatic exp_t e = sb.pop_front();
                    check("rd_dat", rd_dat, e.d);
                    check("rd_last", 64'(rd_last), 64'(e.l));
                end
                if (pop_idx == 0) first_pop_cyc = cyc;
                pop_idx++;
                if (rd_last) begin
                    last_pop_cyc = cyc;
                    pop_idx = 0;
                end
            end
            if (busy) begin
                check("drain_wr_rdy", 64'(wr_rdy), 64'd0);
                check("drain_ram_we", 64'(ram_we), 64'd0);
            end
            if (ram_ce && !ram_we)
                check("read_credit", 64'(outstanding - p < 2), 64'd1);
            outstanding = outstanding + ((ram_ce && !ram_we) ? 1 : 0) - p;
        end
    end

    task automatic write_block(input int n, input logic [7:0] x, input bit partial,
                               input int total, output int first_acc);
        first_acc = -1;
        for (int k = 0; k < n; k++) begin
            automatic logic [7:0] b = 8'(k) ^ x;
            automatic bit acc = 0;
            wr_val  = 1'b1;
            wr_dat  = {8{b}};
            wr_last = partial && (k == n - 1);
            for (int w = 0; w < 1000 && !acc; w++) begin
                @(negedge clk);
                if (wr_rdy) begin
                    acc = 1;
                    check("ram_write_en", 64'(ram_ce && ram_we), 64'd1);
                    check("ram_write_addr", 64'(ram_addr), 64'(k));
                    sb.push_back('{d: {8{b}}, l: (k == total - 1)});
                    if (k == 0) first_acc = cyc;
                    if (k == total - 1) begin
                        lat_armed   = 1;
                        last_wr_cyc = cyc;
                    end
                end
                @(posedge clk); #1;
            end
            if (!acc) begin
                check("write_timeout", 64'd0, 64'd1);
                break;
            end
        end
        wr_val  = 1'b0;
        wr_last = 1'b0;
    endtask

    task automatic wait_drain();
        for (int w = 0; w < 3000 && sb.size() != 0; w++) @(posedge clk);
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
        #1;
    endtask

    int fa;

    initial begin
        // T1: reset values and release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_rdy", 64'(wr_rdy), 64'd0);
        check("rst_rd_val", 64'(rd_val), 64'd0);
        check("rst_rd_last", 64'(rd_last), 64'd0);
        check("rst_rd_dat", rd_dat, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ram_ce", 64'(ram_ce), 64'd0);
        check("rst_ram_we", 64'(ram_we), 64'd0);
        check("rst_ram_addr", 64'(ram_addr), 64'd0);
        rst_n = 1'b1;
        #1 check("release_wr_rdy_low", 64'(wr_rdy), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        check("release_wr_rdy_high", 64'(wr_rdy), 64'd1);

        // T2: back-to-back block, downstream always ready
        rdy_mode = 0;
        write_block(128, 8'h00, 0, 128, fa);
        wait_drain();
        check("t2_burst_span", 64'(last_pop_cyc - first_pop_cyc), 64'd127);

        // T3: downstream ready toggling 1,0,0,1
        rdy_mode = 1;
        write_block(128, 8'h5A, 0, 128, fa);
        wait_drain();

        // T4: next block offered throughout the drain
        rdy_mode = 0;
        write_block(128, 8'h33, 0, 128, fa);
        write_block(128, 8'hC3, 0, 128, fa);
        check("t4_restart_cycle", 64'(fa), 64'(last_pop_cyc + 1));
        wait_drain();

        // T5: reset after 40 writes, then a full block
        write_block(40, 8'h77, 0, 128, fa);
        rst_n = 1'b0;
        sb.delete();
        pop_idx   = 0;
        lat_armed = 0;
        repeat (2) @(posedge clk);
        #1 check("t5_rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        write_block(128, 8'h99, 0, 128, fa);
        wait_drain();

`ifdef BLK_BUF_PARTIAL_EN
        // T6: early block end on the 10th write
        write_block(10, 8'h21, 1, 10, fa);
        wait_drain();
        @(negedge clk);
        check("t6_back_to_fill", 64'(wr_rdy), 64'd1);
        check("t6_busy", 64'(busy), 64'd0);
`endif

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("final_idle_rd_val", 64'(rd_val), 64'd0);
        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
